// File: rtl/fifo_rd_stream_if.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream_if
//   Bundles the two sides of the read-side drainer:
//     - FIFO read port : fifo_rd_en (pop), fifo_rd_data (registered, valid the
//                        cycle after a pop), fifo_rd_empty
//     - output stream  : valid / data / ready
//   modport master : the drainer (drives pops and the stream)
//   modport slave  : the environment (FIFO read port plus stream consumer)
// -----------------------------------------------------------------------------
interface fifo_rd_stream_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  fifo_rd_empty;
  logic                  valid;
  logic [DATA_WIDTH-1:0] data;
  logic                  ready;

  modport master (
    output fifo_rd_en,
    input  fifo_rd_data,
    input  fifo_rd_empty,
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  fifo_rd_en,
    output fifo_rd_data,
    output fifo_rd_empty,
    input  valid,
    input  data,
    output ready
  );
endinterface

// File: rtl/fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream
//   Read-side drainer for a FIFO with registered read data. Pops words through
//   the rd_en/empty port and re-presents them as a valid/ready stream, hiding
//   the one-cycle read latency behind a small circular buffer. Sustains one
//   word per cycle under continuous ready; never drops or duplicates words.
//
// Ports
//   i_clk    : FIFO read clock
//   i_rst_n  : asynchronous active-low reset
//   i_flush  : one-cycle synchronous discard of buffered and in-flight words
//   bus      : fifo_rd_stream_if.master (FIFO read port + output stream)
//   o_level  : words held in the buffer (in-flight word not included)
// -----------------------------------------------------------------------------
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int BUF_DEPTH  = 2,
  parameter int CNT_WIDTH  = $clog2(BUF_DEPTH + 1)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_flush,
  fifo_rd_stream_if.master     bus,
  output logic [CNT_WIDTH-1:0] o_level
);

  localparam int                PTR_W    = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(BUF_DEPTH - 1);
  localparam logic [CNT_WIDTH:0] DEPTH_W = (CNT_WIDTH + 1)'(BUF_DEPTH);
  localparam logic [CNT_WIDTH-1:0] DEPTH_L = CNT_WIDTH'(BUF_DEPTH);

  if (BUF_DEPTH < 2) begin : g_depth_chk
    $error("fifo_rd_stream: BUF_DEPTH must be >= 2");
  end

  logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [CNT_WIDTH-1:0]  level_q;
  logic                  r_pend;     // a popped word arrives on fifo_rd_data this cycle

  logic                  pop_out;    // stream handshake
  logic                  capture;    // in-flight word written into the buffer
  logic                  issue;      // pop request to the FIFO
  logic                  pop_in;     // pop actually taken by the FIFO
  logic [CNT_WIDTH:0]    committed;  // slots owned after this edge, before any new pop

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Issue rule: a new pop is allowed only if a slot is still free once the
  // buffered words plus the in-flight word, minus the word leaving now, are
  // counted. This reservation is what makes overflow impossible.
  // Reset is folded in so the FIFO sees no pop request while held in reset.
  always_comb begin
    pop_out   = (level_q != '0) && bus.ready;
    capture   = r_pend && !i_flush;
    committed = {1'b0, level_q}
              + {{CNT_WIDTH{1'b0}}, r_pend}
              - {{CNT_WIDTH{1'b0}}, pop_out};
    issue     = i_rst_n && !i_flush && (committed < DEPTH_W);
    pop_in    = issue && !bus.fifo_rd_empty;
  end

  assign bus.fifo_rd_en = issue;
  assign bus.valid      = (level_q != '0);
  // Head word read straight from the register array; stays put while stalled
  // because writes only ever land in free slots.
  assign bus.data       = mem_q[rd_ptr_q];
  assign o_level        = level_q;

  // Control state. A flush drops everything, including a handshake in the
  // same cycle; no pop is issued during flush, so r_pend falls as well.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pend   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      r_pend <= pop_in;
      if (i_flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        level_q  <= '0;
      end else begin
        if (capture) wr_ptr_q <= ptr_inc(wr_ptr_q);
        if (pop_out) rd_ptr_q <= ptr_inc(rd_ptr_q);
        level_q <= level_q + CNT_WIDTH'(capture) - CNT_WIDTH'(pop_out);
      end
    end
  end

  // Buffer storage; cleared on reset so the stream word reads zero out of reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
    end else if (capture) begin
      mem_q[wr_ptr_q] <= bus.fifo_rd_data;
    end
  end

  a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    capture |-> (level_q < DEPTH_L));

  a_stall_stable: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (bus.valid && !bus.ready && !i_flush) |=> $stable(bus.data));

endmodule
